mp_row_drain: RTL and testbench

MP_ROW_DRAIN -- requirements
Module: mp_row_drain

---
 rtl/mp_row_drain_pkg.sv | 21 ++
 rtl/mp_row_drain_lane_max.sv | 19 +
 rtl/mp_row_drain.sv | 122 ++++++++++++
 tb/tb_mp_row_drain.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/mp_row_drain_pkg.sv
// rtl/mp_row_drain_pkg.sv - shared constants, state encoding and row-length mapping for mp_row_drain
package mp_row_drain_pkg;

  localparam int LANE_W = 8;
  localparam int LANES  = 4;

  localparam logic [8:0] IFM_W_SHORT   = 9'd26;
  localparam logic [3:0] ROW_N_SHORT   = 4'd7;
  localparam logic [3:0] ROW_N_DEFAULT = 4'd13;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic [3:0] row_len(input logic [8:0] ifm_w);
    return (ifm_w == IFM_W_SHORT) ? ROW_N_SHORT : ROW_N_DEFAULT;
  endfunction

endpackage

// File: rtl/mp_row_drain_lane_max.sv
// rtl/mp_row_drain_lane_max.sv - combinational lane-wise signed maximum of two packed words
module mp_lane_max #(
  parameter int LANE_W = mp_row_drain_pkg::LANE_W,
  parameter int LANES  = mp_row_drain_pkg::LANES
) (
  input  logic [LANE_W*LANES-1:0] a_i,
  input  logic [LANE_W*LANES-1:0] b_i,
  output logic [LANE_W*LANES-1:0] max_o
);

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic signed [LANE_W-1:0] a_l;
    logic signed [LANE_W-1:0] b_l;
    assign a_l = a_i[g*LANE_W +: LANE_W];
    assign b_l = b_i[g*LANE_W +: LANE_W];
    assign max_o[g*LANE_W +: LANE_W] = (a_l > b_l) ? a_l : b_l;
  end

endmodule

// File: rtl/mp_row_drain.sv
// rtl/mp_row_drain.sv - pairs buffered first-row words with a streamed second row and emits lane-wise max
module mp_row_drain #(
  parameter int LANE_W = mp_row_drain_pkg::LANE_W,
  parameter int LANES  = mp_row_drain_pkg::LANES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [8:0]  ifm_width,
  input  logic        buf_full,
  output logic        buf_rd,
  input  logic [31:0] buf_data,
  input  logic        row_valid,
  output logic        row_ready,
  input  logic [31:0] row_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        busy,
  output logic        row_done
);

  import mp_row_drain_pkg::*;

  state_e      state_q, state_d;
  logic [3:0]  n_q, n_d;
  logic [3:0]  rd_cnt_q, rd_cnt_d;
  logic [3:0]  pair_cnt_q, pair_cnt_d;
  logic        pend_q, pend_d;
  logic        hold_v_q, hold_v_d;
  logic [31:0] hold_q, hold_d;
  logic        out_v_q, out_v_d;
  logic [31:0] out_q, out_d;
  logic [31:0] max_w;
  logic        accept;
  logic        rd_go;

  mp_lane_max #(.LANE_W(LANE_W), .LANES(LANES)) u_lane_max (
    .a_i   (hold_q),
    .b_i   (row_data),
    .max_o (max_w)
  );

  assign row_ready = (state_q == ST_RUN) & hold_v_q & (!out_v_q | out_ready);
  assign accept    = row_valid & row_ready;
  // At most one word in flight: either pending from the buffer or sitting in hold.
  assign rd_go     = (state_q == ST_RUN) & (rd_cnt_q < n_q) & !pend_q & (!hold_v_q | accept);

  assign buf_rd    = rd_go;
  assign busy      = (state_q != ST_IDLE);
  assign row_done  = (state_q == ST_DONE);
  assign out_valid = out_v_q;
  assign out_data  = out_q;

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    rd_cnt_d   = rd_cnt_q;
    pair_cnt_d = pair_cnt_q;
    case (state_q)
      ST_IDLE: begin
        rd_cnt_d   = 4'd0;
        pair_cnt_d = 4'd0;
        if (buf_full) begin
          state_d = ST_RUN;
          n_d     = row_len(ifm_width);
        end
      end
      ST_RUN: begin
        if (rd_go) rd_cnt_d = rd_cnt_q + 4'd1;
        if (accept) begin
          pair_cnt_d = pair_cnt_q + 4'd1;
          if ((pair_cnt_q + 4'd1) == n_q) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d    = ST_IDLE;
        rd_cnt_d   = 4'd0;
        pair_cnt_d = 4'd0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pend_d   = rd_go;
    hold_d   = pend_q ? buf_data : hold_q;
    hold_v_d = pend_q | (hold_v_q & !accept);
    out_d    = out_q;
    out_v_d  = out_v_q;
    if (accept) begin
      out_d   = max_w;
      out_v_d = 1'b1;
    end else if (out_ready) begin
      out_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      n_q        <= ROW_N_DEFAULT;
      rd_cnt_q   <= 4'd0;
      pair_cnt_q <= 4'd0;
      pend_q     <= 1'b0;
      hold_v_q   <= 1'b0;
      hold_q     <= 32'd0;
      out_v_q    <= 1'b0;
      out_q      <= 32'd0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      rd_cnt_q   <= rd_cnt_d;
      pair_cnt_q <= pair_cnt_d;
      pend_q     <= pend_d;
      hold_v_q   <= hold_v_d;
      hold_q     <= hold_d;
      out_v_q    <= out_v_d;
      out_q      <= out_d;
    end
  end

endmodule

// File: tb/tb_mp_row_drain.sv
// tb/tb_mp_row_drain.sv - randomized self-checking bench for mp_row_drain against a queue-based reference
module tb_mp_row_drain;

  logic        clk = 1'b0;
  logic        rst;
  logic [8:0]  ifm_width;
  logic        buf_full;
  logic        buf_rd;
  logic [31:0] buf_data;
  logic        row_valid;
  logic        row_ready;
  logic [31:0] row_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        busy;
  logic        row_done;

  int nchk = 0;
  int nerr = 0;

  logic [31:0] bmem [16];
  logic [31:0] rmem [16];
  logic [31:0] exp_q [$];
  int n_exp, rd_cnt, acc_cnt, rv_mode, or_mode, stall_left, busy_cyc;
  bit pend_drive, exp_done, got_done, stall_used, rv_tog, special_next;

  mp_row_drain dut (
    .clk       (clk),
    .rst       (rst),
    .ifm_width (ifm_width),
    .buf_full  (buf_full),
    .buf_rd    (buf_rd),
    .buf_data  (buf_data),
    .row_valid (row_valid),
    .row_ready (row_ready),
    .row_data  (row_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .row_done  (row_done)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [31:0] lane_max(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic signed [7:0] x, y;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      x = a[i*8 +: 8];
      y = b[i*8 +: 8];
      r[i*8 +: 8] = (x > y) ? x : y;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive at the falling edge, then sample what the next rising edge will do.
  task automatic step();
    bit rd, acc, ohs;
    @(negedge clk);
    buf_data = pend_drive ? bmem[rd_cnt-1] : $urandom;
    case (rv_mode)
      0: row_valid = 1'b1;
      1: begin rv_tog = !rv_tog; row_valid = rv_tog; end
      default: row_valid = 1'($urandom_range(0, 1));
    endcase
    row_data = row_valid ? rmem[acc_cnt] : $urandom;
    if (or_mode == 2 && !stall_used && acc_cnt >= 5) begin
      stall_used = 1'b1;
      stall_left = 5;
    end
    if (stall_left > 0) begin
      out_ready = 1'b0;
      stall_left--;
    end else begin
      out_ready = (or_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    #1;
    check("out_valid", out_valid, exp_q.size() != 0);
    if (out_valid && exp_q.size() != 0) check("out_data", out_data, exp_q[0]);
    check("row_done", row_done, exp_done);
    if (!busy || (out_valid && !out_ready)) check("row_ready_blocked", row_ready, 0);
    if (busy) busy_cyc++;
    if (row_done) got_done = 1'b1;
    rd  = buf_rd;
    acc = row_valid && row_ready;
    ohs = out_valid && out_ready;
    exp_done = 1'b0;
    if (rd) begin
      check("rd_within_row", rd_cnt < n_exp, 1);
      if (rd_cnt < n_exp) rd_cnt++;
    end
    pend_drive = rd;
    if (ohs && exp_q.size() != 0) void'(exp_q.pop_front());
    if (acc) begin
      check("acc_within_row", acc_cnt < n_exp, 1);
      if (acc_cnt < n_exp) begin
        exp_q.push_back(lane_max(bmem[acc_cnt], rmem[acc_cnt]));
        acc_cnt++;
        exp_done = (acc_cnt == n_exp);
      end
    end
    check("reads_ahead", (rd_cnt - acc_cnt) inside {0, 1}, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_buf_rd", buf_rd, 0);
    check("rst_row_ready", row_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_row_done", row_done, 0);
    exp_q.delete();
    rd_cnt = 0; acc_cnt = 0; n_exp = 0;
    pend_drive = 1'b0; exp_done = 1'b0; buf_full = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_row(input logic [8:0] w, input int rvm, input int orm, input int abort_at);
    int t;
    for (int i = 0; i < 16; i++) begin
      bmem[i] = $urandom;
      rmem[i] = $urandom;
    end
    if (special_next) begin
      bmem[0] = 32'h807F05FF;
      rmem[0] = 32'h7F800500;
      special_next = 1'b0;
    end
    n_exp = (w == 9'd26) ? 7 : 13;
    rd_cnt = 0; acc_cnt = 0; got_done = 1'b0; stall_used = 1'b0;
    stall_left = 0; busy_cyc = 0; rv_mode = rvm; or_mode = orm;
    ifm_width = w;
    buf_full = 1'b1;
    t = 0;
    while (!got_done && t < 400) begin
      step();
      t++;
      if (busy && buf_full) begin
        buf_full = 1'b0;
        ifm_width = 9'($urandom);
      end
      if (abort_at > 0 && acc_cnt == abort_at) break;
    end
    if (abort_at > 0) begin
      do_reset();
    end else begin
      check("row_done_seen", got_done, 1);
      check("rd_per_row", rd_cnt, n_exp);
      check("pairs_per_row", acc_cnt, n_exp);
      if (rvm == 0 && orm == 0) check("sustained_rate", busy_cyc <= 2*n_exp + 2, 1);
      step();
      check("idle_after_done", busy, 0);
    end
  endtask

  initial begin
    rst = 1'b1; buf_full = 1'b0; ifm_width = '0; row_valid = 1'b0;
    row_data = '0; buf_data = '0; out_ready = 1'b1;
    n_exp = 0; rd_cnt = 0; acc_cnt = 0; rv_mode = 0; or_mode = 0;
    stall_left = 0; busy_cyc = 0; pend_drive = 1'b0; exp_done = 1'b0;
    got_done = 1'b0; stall_used = 1'b0; rv_tog = 1'b0; special_next = 1'b1;

    check("lane_max_ref_a", lane_max(32'h807F05FF, 32'h7F800500), 32'h7F7F0500);
    check("lane_max_ref_b", lane_max(32'h0580007F, 32'h0580FF80), 32'h0580007F);

    do_reset();
    run_row(9'd26, 0, 0, 0);
    run_row(9'd52, 0, 0, 0);
    run_row(9'd26, 1, 0, 0);
    run_row(9'd100, 2, 1, 0);
    run_row(9'd52, 0, 2, 0);
    run_row(9'd52, 0, 0, 3);
    repeat (3) step();
    run_row(9'd52, 0, 0, 0);
    repeat (6) run_row(($urandom_range(0, 1) != 0) ? 9'd26 : 9'($urandom), 2, 1, 0);

    or_mode = 0;
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) step();
    step();
    check("drained", out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end

endmodule
